hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 16-bit five-stage RISC core (IF, ID, EX, MEM, WB). It classifies the instruction in ID, tracks in-flight destination registers for EX/MEM/WB in an internal scoreboard, and generates forwarding selects, load-use and dependency stalls, bubbles and IF/ID flushes. It sits beside the instruction decoder and drives PC, IF/ID and ID/EX register enables.

## Interface
- Parameters:
  - `REG_WIDTH`, 3, register index width.
  - `OPCODE_WIDTH`, 4, opcode width.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `id_valid`  in  1  ID holds a real instruction.
  - `id_opcode`  in  4  decoded opcode.
  - `id_rd`, `id_rs1`, `id_rs2`  in  3 each  decoded register fields.
  - `id_mode`  in  1  decoded mode bit.
  - `ctrl_taken`  in  1  ID branch unit resolves a taken transfer; meaningful only for opcodes 8–14.
  - `pc_write_en`  out  1  PC update enable.
  - `ifid_write_en`  out  1  IF/ID register enable.
  - `ifid_flush`  out  1  clear IF/ID to a bubble.
  - `idex_bubble`  out  1  load a bubble into ID/EX.
  - `fwd_rs1_sel`, `fwd_rs2_sel`, `fwd_rd_sel`  out  2 each  operand source select: 00 regfile, 01 EX, 10 MEM, 11 WB.

## Operation
- **Source classification:**
  - Opcodes 0–2: rs1, rs2.
  - Opcodes 3–6 and 15: rs1.
  - Opcode 7 (SW): rs1 and rd.
  - Opcodes 8–11: rd, plus rs1 only when `id_mode` = 0.
  - Opcode 14 (RET): R7 on the rs1 port.
  - Opcodes 12 and 13: no sources.
- **Destination classification:**
  - Opcodes 0–6 write rd.
  - Opcode 13 (CALL) writes R7.
  - Load = opcodes 5 and 6.
- **R0 rule:** R0 is never a dependency source or destination.
- **Scoreboard:**
  - Three entries (EX, MEM, WB), each holding {valid, dest, is_load}.
  - Each cycle WB←MEM and MEM←EX.
  - EX←ID classification when `id_valid` and not stalled; EX←invalid when stalled.
- **Forwarding:**
  - For each active source, select the youngest matching valid entry: EX over MEM over WB.
  - Otherwise select 00.
  - Inactive sources drive 00.
- **Load-use stall:** any active source matches a valid EX entry with is_load → stall.
- **Stall actions:** `pc_write_en`=0, `ifid_write_en`=0, `idex_bubble`=1.
- **Control transfer:** `ctrl_taken` with `id_valid` and no stall → `ifid_flush`=1 for that cycle. PC redirect is owned by the datapath.
- **Stall priority:** stall suppresses flush. The branch re-evaluates next cycle with forwarded operands.
- **Outputs:** all combinational from scoreboard state plus ID inputs.

## Timing
- **Reset:**
  - All scoreboard valid bits = 0.
  - With `id_valid`=0: `pc_write_en`=1, `ifid_write_en`=1, `ifid_flush`=0, `idex_bubble`=0, all selects 00.
  - Reset mid-operation drops all in-flight tracking immediately.
- **Load-use stall:** exactly 1 cycle. The next cycle forwards from MEM (10).
- **Back-to-back dependencies:** ALU→dependent instruction requires zero stall cycles.
- **CALL then RET:** RET in ID with CALL in EX → `fwd_rs1_sel`=01, no stall.
- **Simultaneous stall and `ctrl_taken`:** stall only; no flush in that cycle.
- **`id_valid`=0:** no stall, no flush. A bubble enters EX.

## Configuration
- **`HAZARD_FWD_EN` defined:** forwarding as above.
- **`HAZARD_FWD_EN` undefined:**
  - All selects are forced to 00.
  - Any active source matching any valid EX/MEM/WB entry stalls.
  - The register file is not write-through, so a dependency stalls up to 3 cycles.
  - The load/ALU distinction is irrelevant.

## Structure
- Shared package `riscpipe_pkg` holds:
  - opcode constants (AND, ADD, SUB, ADDI, ANDI, LW, LB, SW, BGT, BLT, BEQ, BNE, JMP, CALL, RET, SV);
  - `FWD_RF`, `FWD_EX`, `FWD_MEM`, `FWD_WB` encodings;
  - `REG_LINK` = 3'd7;
  - the scoreboard entry typedef.
- One combinational sub-module, `operand_classifier`: opcode/mode/fields → source-active flags, source indices, dest-valid, dest index, is_load.

## Test plan
- **ALU→ALU forwarding:** ADD R1,R2,R3 then SUB R4,R1,R1 → `fwd_rs1_sel`=`fwd_rs2_sel`=01, no stall. Third instruction AND R5,R1,R0 → `fwd_rs1_sel`=10.
- **Load-use:** LW R2 then ADD R3,R2,R2 → one cycle with `pc_write_en`=0 and `idex_bubble`=1, then `fwd_rs1_sel`=10.
- **Taken branch:** BEQ mode=0 with `ctrl_taken`=1 and no hazard → `ifid_flush`=1 for one cycle. Same BEQ behind an LW on its rd → stall first, flush on the following cycle.
- **R0 and mode:**
  - ADDI R0 followed by ADD R1,R0,R0 → selects 00.
  - BNE mode=1 with rs1 field matching an EX dest → no forward on rs1.
- **CALL/RET:** CALL followed by RET → `fwd_rs1_sel`=01.
- **Reset and no-forward build:**
  - `rst_n` low during a load-use stall → outputs return to reset values asynchronously.
  - Without `HAZARD_FWD_EN`: ADD R1 then SUB R4,R1,R2 → 3 stall cycles, selects 00.

Source files
------------

// File: rtl/riscpipe_pkg.sv
// riscpipe_pkg: shared definitions for the 16-bit five-stage RISC pipeline.
// Holds the opcode map, forwarding-select encodings, the link register index
// and the hazard scoreboard entry type used by hazard_controller.
package riscpipe_pkg;

  localparam int REG_W = 3;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BGT  = 4'd8;
  localparam logic [3:0] OP_BLT  = 4'd9;
  localparam logic [3:0] OP_BEQ  = 4'd10;
  localparam logic [3:0] OP_BNE  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;
  localparam logic [REG_W-1:0] REG_LINK = 3'd7;

  // One in-flight instruction's destination as tracked for EX, MEM or WB.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } sb_entry_t;

endpackage

// File: rtl/operand_classifier.sv
// operand_classifier: purely combinational decode of the ID instruction into
// hazard-relevant facts.
// Inputs : opcode, mode, rd, rs1, rs2 fields.
// Outputs: rs1/rs2/rd source-active flags and indices, destination valid and
//          index, is_load, is_xfer (opcode may transfer control).
// R0 is filtered here: it never counts as an active source or destination.
module operand_classifier
  import riscpipe_pkg::*;
(
  input  logic [3:0]       opcode,
  input  logic             mode,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  output logic             rs1_act,
  output logic [REG_W-1:0] rs1_idx,
  output logic             rs2_act,
  output logic [REG_W-1:0] rs2_idx,
  output logic             rd_act,
  output logic [REG_W-1:0] rd_idx,
  output logic             dst_valid,
  output logic [REG_W-1:0] dst_idx,
  output logic             is_load,
  output logic             is_xfer
);

  logic use_rs1_s;
  logic use_rs2_s;
  logic use_rd_s;
  logic wr_s;

  // Opcode table: which register ports are read, what is written.
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    wr_s      = 1'b0;
    rs1_idx   = rs1;
    dst_idx   = rd;
    is_load   = 1'b0;
    is_xfer   = 1'b0;
    case (opcode)
      OP_AND, OP_ADD, OP_SUB: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        wr_s      = 1'b1;
      end
      OP_ADDI, OP_ANDI: begin
        use_rs1_s = 1'b1;
        wr_s      = 1'b1;
      end
      OP_LW, OP_LB: begin
        use_rs1_s = 1'b1;
        wr_s      = 1'b1;
        is_load   = 1'b1;
      end
      OP_SV: begin
        use_rs1_s = 1'b1;
      end
      OP_SW: begin
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
      end
      OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
        // mode=1 selects an immediate form, so rs1 is not read.
        use_rs1_s = ~mode;
        use_rd_s  = 1'b1;
        is_xfer   = 1'b1;
      end
      OP_JMP: begin
        is_xfer = 1'b1;
      end
      OP_CALL: begin
        wr_s    = 1'b1;
        dst_idx = REG_LINK;
        is_xfer = 1'b1;
      end
      OP_RET: begin
        // Return address lives in the link register, read on the rs1 port.
        use_rs1_s = 1'b1;
        rs1_idx   = REG_LINK;
        is_xfer   = 1'b1;
      end
      default: begin
        use_rs1_s = 1'b0;
      end
    endcase
  end

  assign rs2_idx   = rs2;
  assign rd_idx    = rd;
  assign rs1_act   = use_rs1_s && (rs1_idx != REG_ZERO);
  assign rs2_act   = use_rs2_s && (rs2_idx != REG_ZERO);
  assign rd_act    = use_rd_s  && (rd_idx  != REG_ZERO);
  assign dst_valid = wr_s      && (dst_idx != REG_ZERO);

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the five-stage RISC core.
// Tracks EX/MEM/WB destinations in a 3-entry scoreboard and, from that state
// plus the ID instruction, drives stalls, bubbles, IF/ID flush and operand
// forwarding selects (00 RF, 01 EX, 10 MEM, 11 WB). Outputs are combinational.
// Ports: clk, rst_n (async active-low); id_valid, id_opcode, id_rd, id_rs1,
//        id_rs2, id_mode, ctrl_taken in; pc_write_en, ifid_write_en,
//        ifid_flush, idex_bubble, fwd_rs1_sel, fwd_rs2_sel, fwd_rd_sel out.
// Build option HAZARD_FWD_EN: when defined, operands are forwarded and only
// load-use stalls; when undefined, selects stay 00 and any dependency on an
// in-flight destination stalls until it has left WB.
module hazard_controller
  import riscpipe_pkg::*;
#(
  parameter int REG_WIDTH    = 3,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [OPCODE_WIDTH-1:0] id_opcode,
  input  logic [REG_WIDTH-1:0]    id_rd,
  input  logic [REG_WIDTH-1:0]    id_rs1,
  input  logic [REG_WIDTH-1:0]    id_rs2,
  input  logic                    id_mode,
  input  logic                    ctrl_taken,
  output logic                    pc_write_en,
  output logic                    ifid_write_en,
  output logic                    ifid_flush,
  output logic                    idex_bubble,
  output logic [1:0]              fwd_rs1_sel,
  output logic [1:0]              fwd_rs2_sel,
  output logic [1:0]              fwd_rd_sel
);

  sb_entry_t        ex_r, mem_r, wb_r;
  logic             rs1_act_s, rs2_act_s, rd_act_s;
  logic [REG_W-1:0] rs1_idx_s, rs2_idx_s, rd_idx_s, dst_idx_s;
  logic             dst_valid_s, is_load_s, is_xfer_s;
  logic             a1_s, a2_s, ad_s;
  logic             stall_s;
  logic [1:0]       sel1_s, sel2_s, seld_s;

  operand_classifier u_cls (
    .opcode    (id_opcode),
    .mode      (id_mode),
    .rd        (id_rd),
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .rs1_act   (rs1_act_s),
    .rs1_idx   (rs1_idx_s),
    .rs2_act   (rs2_act_s),
    .rs2_idx   (rs2_idx_s),
    .rd_act    (rd_act_s),
    .rd_idx    (rd_idx_s),
    .dst_valid (dst_valid_s),
    .dst_idx   (dst_idx_s),
    .is_load   (is_load_s),
    .is_xfer   (is_xfer_s)
  );

  // A source only counts when ID holds a real instruction.
  assign a1_s = id_valid & rs1_act_s;
  assign a2_s = id_valid & rs2_act_s;
  assign ad_s = id_valid & rd_act_s;

  function automatic logic hit(input logic act, input logic [REG_W-1:0] idx,
                               input sb_entry_t e);
    return act && e.valid && (e.dest == idx);
  endfunction

  function automatic logic [1:0] fwd_select(input logic act,
                                            input logic [REG_W-1:0] idx,
                                            input sb_entry_t ex,
                                            input sb_entry_t mem,
                                            input sb_entry_t wb);
    logic [1:0] sel;
    if (hit(act, idx, ex)) begin
      sel = FWD_EX;
    end else if (hit(act, idx, mem)) begin
      sel = FWD_MEM;
    end else if (hit(act, idx, wb)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selection.
  always_comb begin
    stall_s = 1'b0;
    sel1_s  = FWD_RF;
    sel2_s  = FWD_RF;
    seld_s  = FWD_RF;
`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time.
    stall_s = ex_r.is_load &&
              (hit(a1_s, rs1_idx_s, ex_r) || hit(a2_s, rs2_idx_s, ex_r) ||
               hit(ad_s, rd_idx_s, ex_r));
    sel1_s  = fwd_select(a1_s, rs1_idx_s, ex_r, mem_r, wb_r);
    sel2_s  = fwd_select(a2_s, rs2_idx_s, ex_r, mem_r, wb_r);
    seld_s  = fwd_select(ad_s, rd_idx_s, ex_r, mem_r, wb_r);
`else
    // No bypass: wait until the producer has retired past WB.
    stall_s = hit(a1_s, rs1_idx_s, ex_r) || hit(a1_s, rs1_idx_s, mem_r) ||
              hit(a1_s, rs1_idx_s, wb_r) ||
              hit(a2_s, rs2_idx_s, ex_r) || hit(a2_s, rs2_idx_s, mem_r) ||
              hit(a2_s, rs2_idx_s, wb_r) ||
              hit(ad_s, rd_idx_s, ex_r)  || hit(ad_s, rd_idx_s, mem_r) ||
              hit(ad_s, rd_idx_s, wb_r);
`endif
  end

  assign pc_write_en   = ~stall_s;
  assign ifid_write_en = ~stall_s;
  assign idex_bubble   = stall_s;
  // Stall wins: the branch re-resolves next cycle with good operands.
  assign ifid_flush    = id_valid & is_xfer_s & ctrl_taken & ~stall_s;
  assign fwd_rs1_sel   = sel1_s;
  assign fwd_rs2_sel   = sel2_s;
  assign fwd_rd_sel    = seld_s;

  // Scoreboard shift: ID->EX->MEM->WB; stalls and empty ID insert bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      if (id_valid && !stall_s) begin
        ex_r.valid   <= dst_valid_s;
        ex_r.dest    <= dst_idx_s;
        ex_r.is_load <= is_load_s & dst_valid_s;
      end else begin
        ex_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller.
// Each step drives one ID instruction, samples outputs at the falling edge and
// compares the packed output vector against a hand-computed value. Expected
// sequences cover both builds (HAZARD_FWD_EN defined or not).
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] id_opcode;
  logic [2:0] id_rd, id_rs1, id_rs2;
  logic       id_mode, ctrl_taken;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel, fwd_rd_sel;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] AND_ = 4'd0, ADD = 4'd1, SUB = 4'd2, ADDI = 4'd3;
  localparam logic [3:0] LW = 4'd5, BEQ = 4'd10, BNE = 4'd11;
  localparam logic [3:0] CALL = 4'd13, RET = 4'd14;

  hazard_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_rd         (id_rd),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_mode       (id_mode),
    .ctrl_taken    (ctrl_taken),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .fwd_rs1_sel   (fwd_rs1_sel),
    .fwd_rs2_sel   (fwd_rs2_sel),
    .fwd_rd_sel    (fwd_rd_sel)
  );

  always #5 clk = ~clk;

  wire [9:0] outv = {pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
                     fwd_rs1_sel, fwd_rs2_sel, fwd_rd_sel};

  // Expected output vector from stall/flush/select intent.
  function automatic logic [9:0] ev(input logic stall, input logic flush,
                                    input logic [1:0] s1, input logic [1:0] s2,
                                    input logic [1:0] sd);
    return {~stall, ~stall, flush, stall, s1, s2, sd};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic mode, input logic taken);
    id_valid   = v;
    id_opcode  = op;
    id_rd      = rd;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_mode    = mode;
    ctrl_taken = taken;
  endtask

  // One ID cycle: drive, sample at negedge, advance past the next posedge.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic mode,
                      input logic taken, input logic [9:0] exp);
    drive(v, op, rd, rs1, rs2, mode, taken);
    @(negedge clk);
    check_eq(tag, {6'd0, outv}, {6'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      step("drain", 1'b0, ADD, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1,
           ev(1'b0, 1'b0, 2'b00, 2'b00, 2'b00));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
    #3;
    check_eq("reset", {6'd0, outv}, {6'd0, ev(1'b0, 1'b0, 2'b00, 2'b00, 2'b00)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef HAZARD_FWD_EN
    // ALU->ALU forwarding, then MEM forward on the third instruction.
    step("alu_add", 1'b1, ADD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("alu_sub_ex", 1'b1, SUB, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, ev(0, 0, 2'b01, 2'b01, 2'b00));
    step("alu_and_mem", 1'b1, AND_, 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b10, 2'b00, 2'b00));
    drain();
    // Load-use: one stall cycle then MEM forward.
    step("lu_lw", 1'b1, LW, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("lu_stall", 1'b1, ADD, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, ev(1, 0, 2'b01, 2'b01, 2'b00));
    step("lu_mem", 1'b1, ADD, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b10, 2'b10, 2'b00));
    drain();
    // Taken branch alone, then behind a load on its rd.
    step("br_flush", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(0, 1, 2'b00, 2'b00, 2'b00));
    step("br_lw", 1'b1, LW, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("br_stall", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(1, 0, 2'b00, 2'b00, 2'b01));
    step("br_after", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(0, 1, 2'b00, 2'b00, 2'b10));
    drain();
    // R0 rule and branch immediate mode.
    step("r0_addi", 1'b1, ADDI, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("r0_add", 1'b1, ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drain();
    step("mode_add", 1'b1, ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("mode_bne", 1'b1, BNE, 3'd5, 3'd3, 3'd0, 1'b1, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drain();
    // CALL then RET: link register forwarded from EX.
    step("call", 1'b1, CALL, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("ret", 1'b1, RET, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b01, 2'b00, 2'b00));
    drain();
    // Async reset during a load-use stall.
    step("rst_lw", 1'b1, LW, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drive(1'b1, ADD, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rst_pre", {6'd0, outv}, {6'd0, ev(1, 0, 2'b01, 2'b01, 2'b00)});
`else
    // Dependency on ADD R1 stalls through EX, MEM and WB.
    step("nf_add", 1'b1, ADD, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("nf_stall_ex", 1'b1, SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, ev(1, 0, 2'b00, 2'b00, 2'b00));
    step("nf_stall_mem", 1'b1, SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, ev(1, 0, 2'b00, 2'b00, 2'b00));
    step("nf_stall_wb", 1'b1, SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, ev(1, 0, 2'b00, 2'b00, 2'b00));
    step("nf_go", 1'b1, SUB, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("nf_dep_sub", 1'b1, ADD, 3'd5, 3'd4, 3'd0, 1'b0, 1'b0, ev(1, 0, 2'b00, 2'b00, 2'b00));
    drain();
    // Taken branch alone, then behind an ALU op on its rd.
    step("br_flush", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(0, 1, 2'b00, 2'b00, 2'b00));
    step("br_add", 1'b1, ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) begin
      step("br_stall", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(1, 0, 2'b00, 2'b00, 2'b00));
    end
    step("br_after", 1'b1, BEQ, 3'd3, 3'd4, 3'd0, 1'b0, 1'b1, ev(0, 1, 2'b00, 2'b00, 2'b00));
    drain();
    // R0 rule and branch immediate mode.
    step("r0_addi", 1'b1, ADDI, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("r0_add", 1'b1, ADD, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drain();
    step("mode_add", 1'b1, ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("mode_bne", 1'b1, BNE, 3'd5, 3'd3, 3'd0, 1'b1, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drain();
    // CALL then RET: link dependency stalls without bypass.
    step("call", 1'b1, CALL, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    step("ret", 1'b1, RET, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, ev(1, 0, 2'b00, 2'b00, 2'b00));
    drain();
    // Async reset during a dependency stall on a load.
    step("rst_lw", 1'b1, LW, 3'd2, 3'd0, 3'd0, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));
    drive(1'b1, ADD, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("rst_pre", {6'd0, outv}, {6'd0, ev(1, 0, 2'b00, 2'b00, 2'b00)});
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {6'd0, outv}, {6'd0, ev(0, 0, 2'b00, 2'b00, 2'b00)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rst_after", 1'b1, ADD, 3'd3, 3'd2, 3'd2, 1'b0, 1'b0, ev(0, 0, 2'b00, 2'b00, 2'b00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
